// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and constants for the gshare branch predictor.
package gshare_branch_predictor_pkg;

  // Widest global history the in-flight entry can carry; GHR_WIDTH must not exceed it.
  localparam int unsigned GHR_MAX_WIDTH = 16;

  // Saturating counter steps and floor; the ceiling depends on the counter width.
  localparam int unsigned CTR_INC   = 1;
  localparam int unsigned CTR_DEC   = 1;
  localparam int unsigned CTR_FLOOR = 0;

  // Highest value a width-bit saturating counter may hold.
  function automatic int unsigned ctr_ceil(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // One unresolved prediction: the PHT slot it read, the history it saw, and its guess.
  typedef struct packed {
    logic [GHR_MAX_WIDTH-1:0] index;
    logic [GHR_MAX_WIDTH-1:0] ghr;
    logic                     prediction;
  } inflight_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular queue of unresolved predictions with push, pop and single-cycle flush.
module bp_inflight_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // Storage write; slots are only meaningful while count covers them.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the queue in one edge.
  // NOTE: the storage array above is deliberately left without reset -- count marks what is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: PC xor speculative history indexes a table of saturating counters.
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int GHR_WIDTH      = 4,
  parameter int PC_WIDTH       = 32,
  parameter int CTR_WIDTH      = 2,
  parameter int INFLIGHT_DEPTH = 4,
  parameter int STALL_PENALTY  = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 predict_request,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 predict_ready,
  output logic                 pred_valid,
  output logic                 predicted_taken,
  input  logic                 update_enable,
  input  logic                 actual_taken,
  output logic                 mispredict,
  output logic                 update_err,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int PHT_SIZE    = 1 << GHR_WIDTH;
  localparam int FIFO_CNT_W  = $clog2(INFLIGHT_DEPTH + 1);
  localparam int ENTRY_WIDTH = $bits(inflight_entry_t);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = CTR_WIDTH'(ctr_ceil(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = CTR_WIDTH'(CTR_FLOOR);
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

  logic [GHR_WIDTH-1:0]  spec_ghr;
  logic [CTR_WIDTH-1:0]  pht [PHT_SIZE];
  logic [GHR_WIDTH-1:0]  index;
  logic [GHR_WIDTH-1:0]  pop_index;
  logic [GHR_WIDTH-1:0]  pop_ghr;
  logic                  prediction;
  logic                  update_valid;
  logic                  is_mispredict;
  logic                  correct_update;
  logic                  accept;
  logic                  err;
  inflight_entry_t       push_entry;
  inflight_entry_t       pop_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  unused_bits;

  // Only the index bits of pc and the live part of each entry feed the logic.
  assign unused_bits = ^{pc, pop_entry, fifo_count};

  // Request/resolve decode: a mispredict flushes and drops any same-cycle request,
  // while a correct resolve frees a slot so a full queue can still accept.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    push_entry            = '0;
    index                 = pc[GHR_WIDTH+1:2] ^ spec_ghr;
    prediction            = pht[index][CTR_WIDTH-1];
    pop_index             = pop_entry.index[GHR_WIDTH-1:0];
    pop_ghr               = pop_entry.ghr[GHR_WIDTH-1:0];
    update_valid          = update_enable && !fifo_empty;
    is_mispredict         = update_valid && (actual_taken != pop_entry.prediction);
    correct_update        = update_valid && !is_mispredict;
    predict_ready         = !fifo_full;
    accept                = predict_request && (predict_ready || correct_update) && !is_mispredict;
    err                   = update_enable && fifo_empty && !accept;
    push_entry.index      = GHR_MAX_WIDTH'(index);
    push_entry.ghr        = GHR_MAX_WIDTH'(spec_ghr);
    push_entry.prediction = prediction;
  end

  bp_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_entry),
    .pop       (correct_update),
    .flush     (is_mispredict),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Speculative history: recover from the mispredicted entry, else shift in each new guess.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr <= '0;
    end else if (is_mispredict) begin
      spec_ghr <= {pop_ghr[GHR_WIDTH-2:0], actual_taken};
    end else if (accept) begin
      spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], prediction};
    end
  end

  // Pattern table training; the table is small and must start weakly taken, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        pht[i] <= CTR_WEAK;
      end
    end else if (update_valid) begin
      if (actual_taken) begin
        if (pht[pop_index] != CTR_MAX) pht[pop_index] <= pht[pop_index] + CTR_WIDTH'(CTR_INC);
      end else begin
        if (pht[pop_index] != CTR_MIN) pht[pop_index] <= pht[pop_index] - CTR_WIDTH'(CTR_DEC);
      end
    end
  end

  // Registered prediction result and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid      <= 1'b0;
      predicted_taken <= 1'b0;
      mispredict      <= 1'b0;
      update_err      <= 1'b0;
    end else begin
      pred_valid      <= accept;
      predicted_taken <= accept && prediction;
      mispredict      <= is_mispredict;
      update_err      <= err;
    end
  end

  // Performance counters, wrapping at their natural width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      stall_cycles     <= '0;
    end else begin
      if (update_valid) branch_count <= branch_count + CNT_WIDTH'(1);
      if (is_mispredict) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        stall_cycles     <= stall_cycles + CNT_WIDTH'(STALL_PENALTY);
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed scenarios plus random traffic,
// scored against a queue/array model of the predictor's rules.
module tb_gshare_branch_predictor;

  localparam int GHR_W   = 4;
  localparam int PC_W    = 32;
  localparam int CTR_W   = 2;
  localparam int DEPTH   = 4;
  localparam int PENALTY = 5;
  localparam int CNT_W   = 32;
  localparam int PHT_N   = 1 << GHR_W;
  localparam int WEAK    = 1 << (CTR_W - 1);
  localparam int CTR_TOP = (1 << CTR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             predict_request = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             update_enable = 1'b0;
  logic             actual_taken = 1'b0;
  logic             predict_ready;
  logic             pred_valid;
  logic             predicted_taken;
  logic             mispredict;
  logic             update_err;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  gshare_branch_predictor #(
    .GHR_WIDTH      (GHR_W),
    .PC_WIDTH       (PC_W),
    .CTR_WIDTH      (CTR_W),
    .INFLIGHT_DEPTH (DEPTH),
    .STALL_PENALTY  (PENALTY),
    .CNT_WIDTH      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .predict_request  (predict_request),
    .pc               (pc),
    .predict_ready    (predict_ready),
    .pred_valid       (pred_valid),
    .predicted_taken  (predicted_taken),
    .update_enable    (update_enable),
    .actual_taken     (actual_taken),
    .mispredict       (mispredict),
    .update_err       (update_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .stall_cycles     (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: counter table, true history word, in-flight queue, counters.
  typedef struct {
    int idx;
    int ghr;
    bit pred;
  } m_entry_t;

  typedef struct {
    bit pv;
    bit mis;
    bit err;
    int bc;
    int mc;
    int st;
  } exp_t;

  int       m_pht [PHT_N];
  int       m_ghr;
  m_entry_t m_q [$];
  int       m_bc, m_mc, m_st;
  exp_t     cyc_q [$];
  bit       pred_q [$];

  task automatic model_reset();
    foreach (m_pht[i]) m_pht[i] = WEAK;
    m_ghr = 0;
    m_q.delete();
    m_bc = 0;
    m_mc = 0;
    m_st = 0;
    cyc_q.delete();
    pred_q.delete();
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic step(input bit req, input logic [31:0] p, input bit upd, input bit act);
    int       idx;
    bit       pred, upd_v, mis, acc, err;
    m_entry_t head;
    exp_t     e;
    @(negedge clk);
    predict_request = req;
    pc              = p;
    update_enable   = upd;
    actual_taken    = act;
    check("predict_ready", predict_ready, m_q.size() < DEPTH);
    idx   = int'((p >> 2) & (PHT_N - 1)) ^ m_ghr;
    pred  = (m_pht[idx] >= WEAK);
    upd_v = upd && (m_q.size() > 0);
    head  = '{idx: 0, ghr: 0, pred: 1'b0};
    if (upd_v) head = m_q[0];
    mis   = upd_v && (act != head.pred);
    acc   = req && !mis && ((m_q.size() < DEPTH) || upd_v);
    err   = upd && (m_q.size() == 0) && !acc;
    if (upd_v) begin
      void'(m_q.pop_front());
      m_bc++;
      if (act) begin
        if (m_pht[head.idx] < CTR_TOP) m_pht[head.idx]++;
      end else begin
        if (m_pht[head.idx] > 0) m_pht[head.idx]--;
      end
      if (mis) begin
        m_mc++;
        m_st += PENALTY;
        m_ghr = ((head.ghr << 1) | int'(act)) & (PHT_N - 1);
        m_q.delete();
      end
    end
    if (acc) begin
      m_q.push_back('{idx: idx, ghr: m_ghr, pred: pred});
      m_ghr = ((m_ghr << 1) | int'(pred)) & (PHT_N - 1);
      pred_q.push_back(pred);
    end
    e = '{pv: acc, mis: mis, err: err, bc: m_bc, mc: m_mc, st: m_st};
    cyc_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents after each edge with the queued expectations.
  int   dut_mis_seen = 0;
  exp_t mon_e;
  bit   mon_p;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (mispredict) dut_mis_seen++;
      if (pred_valid) begin
        if (pred_q.size() == 0) begin
          check("pred_valid_unexpected", pred_valid, 0);
        end else begin
          mon_p = pred_q.pop_front();
          check("predicted_taken", predicted_taken, mon_p);
        end
      end
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        check("pred_valid", pred_valid, mon_e.pv);
        check("mispredict", mispredict, mon_e.mis);
        check("update_err", update_err, mon_e.err);
        check("branch_count", branch_count, 64'(mon_e.bc));
        check("mispredict_count", mispredict_count, 64'(mon_e.mc));
        check("stall_cycles", stall_cycles, 64'(mon_e.st));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pred_valid"}, pred_valid, 0);
    check({tag, "_predicted_taken"}, predicted_taken, 0);
    check({tag, "_mispredict"}, mispredict, 0);
    check({tag, "_update_err"}, update_err, 0);
    check({tag, "_branch_count"}, branch_count, 0);
    check({tag, "_mispredict_count"}, mispredict_count, 0);
    check({tag, "_stall_cycles"}, stall_cycles, 0);
  endtask

  task automatic do_reset();
    predict_request = 1'b0;
    update_enable   = 1'b0;
    actual_taken    = 1'b0;
    rst_n           = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  int snap_mis;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_reset", predict_ready, 1);

    // First prediction: table starts weakly taken, answer one cycle later.
    step(1, 32'h100, 0, 0);
    @(posedge clk); #2;
    check("first_pred_valid", pred_valid, 1);
    check("first_pred_taken", predicted_taken, 1);

    // Fill the queue; a fifth request is refused.
    for (int i = 1; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 0, 0);
    step(1, 32'h140, 0, 0);
    @(posedge clk); #2;
    check("fifth_no_pred_valid", pred_valid, 0);

    // Full queue, correct resolve plus request: both happen.
    step(1, 32'h144, 1, 1);
    @(posedge clk); #2;
    check("full_bypass_accept", pred_valid, 1);

    // Down to three in flight, then a mispredict with a colliding request: flush wins.
    step(0, 32'h0, 1, 1);
    step(1, 32'h148, 1, 0);
    @(posedge clk); #2;
    check("flush_mispredict_pulse", mispredict, 1);
    check("flush_drops_request", pred_valid, 0);
    check("flush_stall_cycles", stall_cycles, 5);

    // Update with nothing in flight.
    step(0, 32'h0, 1, 0);
    @(posedge clk); #2;
    check("empty_update_err", update_err, 1);
    check("empty_update_branch_count", branch_count, 64'(m_bc));
    step(1, 32'h100, 0, 0);
    step(0, 32'h0, 1, 1);

    // T,T,T,N loop at one PC, each branch predicted then resolved.
    do_reset();
    snap_mis = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, 32'h100, 0, 0);
      if (i == 30) snap_mis = dut_mis_seen;
      step(0, 32'h0, 1, (i % 4) != 3);
    end
    step(0, 32'h0, 0, 0);
    @(posedge clk); #2;
    check("pattern_branch_count", branch_count, 50);
    check("pattern_stall_relation", stall_cycles, 64'(mispredict_count) * PENALTY);
    check("pattern_mis_bound", mispredict_count <= 10, 1);
    check("pattern_late_mispredicts", dut_mis_seen - snap_mis, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit req, upd, act;
      req = ($urandom_range(0, 3) != 0);
      upd = ($urandom_range(0, 2) == 0);
      act = 1'($urandom_range(0, 1));
      if (upd && req && (m_q.size() == 0)) upd = 1'b0;
      step(req, $urandom, upd, act);
    end
    step(0, 32'h0, 0, 0);
    @(posedge clk); #2;
    check("pred_queue_drained", pred_q.size(), 0);

    // Reset mid-operation with two in flight.
    do_reset();
    step(1, 32'h200, 0, 0);
    step(1, 32'h204, 0, 0);
    @(posedge clk); #3;
    predict_request = 1'b0;
    update_enable   = 1'b0;
    rst_n           = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    check("midreset_ready", predict_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 32'h0, 1, 1);
    @(posedge clk); #2;
    check("post_reset_update_err", update_err, 1);
    check("post_reset_no_mispredict", mispredict, 0);
    step(0, 32'h0, 0, 0);
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 The block SHALL have parameter GHR_WIDTH, default 4: global history bits; the PHT has 2^GHR_WIDTH entries.
REQ-002 The block SHALL have parameter PC_WIDTH, default 32: branch PC width.
REQ-003 The block SHALL have parameter CTR_WIDTH, default 2: saturating counter width, >=1.
REQ-004 The block SHALL have parameter INFLIGHT_DEPTH, default 4: maximum unresolved predictions, power of 2.
REQ-005 The block SHALL have parameter STALL_PENALTY, default 5: stall cycles charged per mispredict.
REQ-006 The block SHALL have parameter CNT_WIDTH, default 32: performance counter width.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port predict_request, input, 1 bit: request a prediction for pc.
REQ-010 The block SHALL have port pc, input, PC_WIDTH bits: branch address.
REQ-011 The block SHALL have port predict_ready, output, 1 bit: a request is accepted this cycle.
REQ-012 The block SHALL have port pred_valid, output, 1 bit: predicted_taken is valid.
REQ-013 The block SHALL have port predicted_taken, output, 1 bit: prediction result.
REQ-014 The block SHALL have port update_enable, input, 1 bit: resolve the oldest in-flight branch.
REQ-015 The block SHALL have port actual_taken, input, 1 bit: the resolved outcome.
REQ-016 The block SHALL have port mispredict, output, 1 bit: one-cycle pulse, the resolved branch was mispredicted.
REQ-017 The block SHALL have port update_err, output, 1 bit: one-cycle pulse, update arrived with nothing in flight.
REQ-018 The block SHALL have ports branch_count, mispredict_count and stall_cycles, outputs, CNT_WIDTH bits each: performance counters.

Function
REQ-019 The block SHALL compute index = pc[GHR_WIDTH+1:2] XOR spec_ghr.
REQ-020 The block SHALL accept a request when predict_request and predict_ready are both high; predict_ready SHALL equal NOT full.
REQ-021 On acceptance, the block SHALL register pred_valid=1 and predicted_taken=MSB of PHT[index] on the next rising edge; latency is 1 cycle and pred_valid is otherwise 0.
REQ-022 On acceptance, the block SHALL push {index, spec_ghr, prediction} into the in-flight FIFO and set spec_ghr = {spec_ghr[GHR_WIDTH-2:0], prediction}.
REQ-023 On update_enable with the FIFO non-empty, the block SHALL pop the oldest entry and move PHT[entry.index] up by 1 if actual_taken or down by 1 if not, saturating at 0 and 2^CTR_WIDTH-1.
REQ-024 Every valid update SHALL increment branch_count by 1.
REQ-025 If actual_taken differs from entry.prediction, the block SHALL, on the same edge: pulse mispredict; add 1 to mispredict_count; add STALL_PENALTY to stall_cycles; set spec_ghr = {entry.ghr[GHR_WIDTH-2:0], actual_taken}; flush the FIFO so count=0.
REQ-026 On a simultaneous accepted predict and mispredicting update, the flush SHALL win: the request is dropped, nothing is pushed, pred_valid stays 0 next cycle, and spec_ghr takes the recovered value.
REQ-027 On a simultaneous predict and correct update, the push and pop SHALL both occur, the count is unchanged, and the predict is accepted even when the FIFO is full.
REQ-028 On a same-index PHT read and write in one cycle, the read SHALL return the pre-update value.
REQ-029 update_enable with the FIFO empty and no simultaneous push SHALL pulse update_err and change no state.
REQ-030 Performance counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-031 FIFO pointers SHALL wrap modulo INFLIGHT_DEPTH; full means count==INFLIGHT_DEPTH and empty means count==0.

Reset
REQ-032 While rst_n=0, asynchronously: spec_ghr=0; FIFO count and pointers 0; all PHT entries = 2^(CTR_WIDTH-1) (weakly taken); pred_valid, predicted_taken, mispredict, update_err = 0; all counters = 0; predict_ready=1 from the first cycle after release.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries, and no pulse SHALL be emitted for them.

Structure
REQ-034 A shared package SHALL hold the in-flight entry struct typedef (index, ghr, prediction) and the counter increment/decrement saturation constants.
REQ-035 The in-flight queue SHALL be one sub-module, bp_inflight_fifo (push/pop/flush, full/empty, count), parametrised by depth and entry width.

Verification
REQ-036 Scenario: reset, then predict pc=0x100 -> pred_valid=1 one cycle later with predicted_taken=1.
REQ-037 Scenario: 4 predicts, no update -> predict_ready=0 after the 4th; a 5th request produces no pred_valid.
REQ-038 Scenario: 3 in flight, the oldest predicted 1, update actual_taken=0 -> mispredict pulse, FIFO count=0, spec_ghr={old_ghr[2:0],0}, stall_cycles=5.
REQ-039 Scenario: update_enable on an empty FIFO -> update_err pulse, and branch_count, PHT and GHR unchanged.
REQ-040 Scenario: 50 branches at pc=0x100, pattern T,T,T,N repeating, each predicted then resolved -> branch_count=50, stall_cycles=5*mispredict_count, and mispredict_count at most 10 with no mispredicts in the last 20.
REQ-041 Scenario: rst_n dropped with 2 in flight -> all outputs read their reset values immediately, and a following update gives update_err.
